// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..w-1 (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: diff = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (result = a - b), LSB first, one bit per clock.
// Optional build macro SERIAL_SUB_ZERO_FLAG_EN adds a serially tracked zero flag output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             borrow_reg;
  logic             diff;
  logic             bout;
  logic [WIDTH-1:0] acc_next;
  logic             last_bit;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow_reg),
    .diff (diff),
    .bout (bout)
  );

  // Partial difference fills from the MSB side so bit 0 of a lands at result[0].
  assign acc_next = {diff, acc[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic nz_reg;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset also clears the datapath so
  // result reads 0 after an aborted operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      cnt        <= '0;
      borrow_reg <= 1'b0;
      result     <= '0;
      borrow     <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      nz_reg     <= 1'b0;
      zero       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh       <= a;
            b_sh       <= b;
            acc        <= '0;
            cnt        <= '0;
            borrow_reg <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SHIFT;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            nz_reg     <= 1'b0;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          a_sh       <= a_sh >> 1;
          b_sh       <= b_sh >> 1;
          acc        <= acc_next;
          borrow_reg <= bout;
          cnt        <= cnt + 1'b1;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
          nz_reg     <= nz_reg | diff;
`endif
          if (last_bit) begin
            // On the last bit a_sh[0]/b_sh[0] hold the operand sign bits.
            result   <= acc_next;
            borrow   <= bout;
            overflow <= (a_sh[0] ^ b_sh[0]) & (diff ^ a_sh[0]);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero     <= ~(nz_reg | diff);
`endif
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
